// File: rtl/router_pkg.sv
// Shared mesh-router constants: port count, flit width, port indices and VC encoding.
package router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 64;

    localparam int PORT_N  = 0;
    localparam int PORT_E  = 1;
    localparam int PORT_S  = 2;
    localparam int PORT_W  = 3;
    localparam int PORT_PE = 4;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    // The phase selects which VC may use the link this cycle.
    function automatic logic vc_for_phase(input logic phase);
        return phase ? VC_ODD : VC_EVEN;
    endfunction

endpackage

// File: rtl/router_output_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int N     = 5,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            // Candidate index is (ptr + k) mod N; ptr is always < N so one subtract suffices.
            sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            cand = sum[PTR_W-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/router_output_arbiter.sv
// Per-output-port arbiter: VC-phase-gated round-robin over the input channels,
// combinational grant/blocked, and a registered output link.
module router_output_arbiter
    import router_pkg::*;
#(
    parameter int NUM_IN = NUM_PORTS,
    parameter int DATA_W = FLIT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     polarity,
    input  logic [NUM_IN-1:0]        req,
    input  logic [NUM_IN-1:0]        req_vc,
    input  logic [NUM_IN*DATA_W-1:0] data_in,
    input  logic                     downstream_ready,
    output logic [NUM_IN-1:0]        grant,
    output logic [NUM_IN-1:0]        blocked,
    output logic                     send_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     vc_out
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [DATA_W-1:0] flit [NUM_IN];
    logic [PTR_W-1:0]  rr_ptr [2];
    logic [NUM_IN-1:0] eligible;
    logic [NUM_IN-1:0] pick_req;
    logic [NUM_IN-1:0] pick_gnt;
    logic [PTR_W-1:0]  win_idx;
    logic              win_any;
    logic [PTR_W-1:0]  ptr_next;

    logic              send_p1;
    logic [DATA_W-1:0] data_p1;
    logic              vc_p1;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign flit[g] = data_in[g*DATA_W +: DATA_W];
    end

    // Stage 0: eligibility and arbitration, all combinational.
    assign eligible = req & ~(req_vc ^ {NUM_IN{polarity}});
    assign pick_req = (!reset && downstream_ready) ? eligible : '0;

    rr_pick #(
        .N     (NUM_IN),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (pick_req),
        .ptr (rr_ptr[polarity]),
        .gnt (pick_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign grant    = pick_gnt;
    assign blocked  = reset ? '0 : (req & ~pick_gnt);
    assign ptr_next = (win_idx == PTR_W'(NUM_IN - 1)) ? '0 : win_idx + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr[0] <= '0;
            rr_ptr[1] <= '0;
        end else if (win_any) begin
            rr_ptr[polarity] <= ptr_next;
        end
    end

    // Stage 1: output link register; an idle cycle drives all-zero onto the link.
    always_ff @(posedge clk) begin
        if (reset) begin
            send_p1 <= 1'b0;
            data_p1 <= '0;
            vc_p1   <= 1'b0;
        end else if (win_any) begin
            send_p1 <= 1'b1;
            data_p1 <= flit[win_idx];
            vc_p1   <= vc_for_phase(polarity);
        end else begin
            send_p1 <= 1'b0;
            data_p1 <= '0;
            vc_p1   <= 1'b0;
        end
    end

    assign send_out = send_p1;
    assign data_out = data_p1;
    assign vc_out   = vc_p1;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter with a scoreboard-fed output monitor.
module tb_router_output_arbiter;
    import router_pkg::*;

    localparam int N = NUM_PORTS;
    localparam int W = FLIT_W;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               polarity;
    logic [N-1:0]       req;
    logic [N-1:0]       req_vc;
    logic [N*W-1:0]     data_in;
    logic               downstream_ready;
    logic [N-1:0]       grant;
    logic [N-1:0]       blocked;
    logic               send_out;
    logic [W-1:0]       data_out;
    logic               vc_out;

    logic [W-1:0] din [N];
    exp_t         sb [$];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        data_in = '0;
        for (int i = 0; i < N; i++) data_in[i*W +: W] = din[i];
    end

    router_output_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .polarity         (polarity),
        .req              (req),
        .req_vc           (req_vc),
        .data_in          (data_in),
        .downstream_ready (downstream_ready),
        .grant            (grant),
        .blocked          (blocked),
        .send_out         (send_out),
        .data_out         (data_out),
        .vc_out           (vc_out)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid flit on the link must match the oldest expected grant.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (send_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_send: got data %h with nothing expected", data_out);
            end else begin
                e = sb.pop_front();
                chk("data_out", data_out, e.d);
                chk("vc_out", {{(W-1){1'b0}}, vc_out}, {{(W-1){1'b0}}, e.v});
            end
        end
    end

    // One cycle: drive inputs, check combinational grant/blocked, queue the expected flit.
    task automatic step(input logic rst, input logic pol, input logic rdy,
                        input logic [N-1:0] rq, input logic [N-1:0] rv,
                        input logic [N-1:0] eg, input logic [N-1:0] eb);
        exp_t e;
        @(negedge clk);
        reset            = rst;
        polarity         = pol;
        downstream_ready = rdy;
        req              = rq;
        req_vc           = rv;
        #1;
        chk("grant", W'(grant), W'(eg));
        chk("blocked", W'(blocked), W'(eb));
        if (eg != '0) begin
            e.d = '0;
            for (int i = 0; i < N; i++) if (eg[i]) e.d = din[i];
            e.v = pol;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        if (eg == '0) begin
            chk("idle_send_out", W'(send_out), '0);
            chk("idle_data_out", data_out, '0);
            chk("idle_vc_out", W'(vc_out), '0);
        end
    endtask

    initial begin
        din[PORT_N]  = 64'h0000_0000_0000_00A5;
        din[PORT_E]  = 64'h0123_4567_89AB_CDEF;
        din[PORT_S]  = 64'hFEDC_BA98_7654_3210;
        din[PORT_W]  = 64'h8000_0000_0000_0001;
        din[PORT_PE] = 64'h5A5A_0000_FFFF_1234;
        reset = 1'b1; polarity = 1'b0; downstream_ready = 1'b1; req = '0; req_vc = '0;

        // Reset with every input requesting: no grant, nothing blocked, link idle.
        step(1, 0, 1, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
        step(1, 0, 1, 5'b11111, 5'b00000, 5'b00000, 5'b00000);

        // Single requester, then pointer advanced to 1 picks input 1 over input 0.
        step(0, 0, 1, 5'b00001, 5'b00000, 5'b00001, 5'b00000);
        step(0, 0, 1, 5'b00011, 5'b00000, 5'b00010, 5'b00001);

        // All five on the even VC with polarity toggling: rotation 0,1,2,3,4,0.
        step(1, 1, 1, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) step(0, 0, 1, 5'b11111, 5'b00000, N'(1 << ((i / 2) % N)), 5'b11111 & ~N'(1 << ((i / 2) % N)));
            else            step(0, 1, 1, 5'b11111, 5'b00000, 5'b00000, 5'b11111);
        end

        // Odd pointer untouched by even-phase traffic: starts at 0, picks input 0.
        step(0, 1, 1, 5'b00011, 5'b00011, 5'b00001, 5'b00010);
        // Mixed VCs in odd phase: only input 4 is eligible.
        step(0, 1, 1, 5'b10010, 5'b10000, 5'b10000, 5'b00010);

        // Downstream stall: everything blocked, pointer (1) held.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 5'b01010, 5'b00000, 5'b00000, 5'b01010);
        step(0, 0, 1, 5'b01010, 5'b00000, 5'b00010, 5'b01000);
        step(0, 0, 1, 5'b01010, 5'b00000, 5'b01000, 5'b00010);

        // Pointer now 4: input 4 wins, then wrap to 0 lets input 0 win.
        step(0, 0, 1, 5'b10001, 5'b00000, 5'b10000, 5'b00001);
        step(0, 0, 1, 5'b10001, 5'b00000, 5'b00001, 5'b10000);

        // Grant (pointer moves to 2), reset next cycle, then restart from 0 picks input 1 not 2.
        step(0, 0, 1, 5'b00110, 5'b00000, 5'b00010, 5'b00100);
        step(1, 0, 1, 5'b00110, 5'b00000, 5'b00000, 5'b00000);
        din[PORT_E] = '0;
        step(0, 0, 1, 5'b00110, 5'b00000, 5'b00010, 5'b00100);
        step(0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
